// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display logic.
package hex_disp_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2
  } scan_state_e;

  // All segments dark (active-low outputs).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}; entry 15 is the MSB slice.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = GLYPH_TBL[nib];

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// A one-deep shadow register takes loads at any time; it is committed to the
// displayed value only at frame boundaries so a frame never mixes values.
module hex_scan_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DWELL    = 50000,
  parameter int GAP      = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  blank_en,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame_done
);

  // One counter serves both the gap and the dwell phases.
  localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_ONE    = DIGITS'(1);

  scan_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  disp_q, disp_d;
  logic [4*DIGITS-1:0]  pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [6:0]           seg_n_q, seg_n_d;
  logic [DIGITS-1:0]    dig_n_q, dig_n_d;
  logic                 frame_done_q, frame_done_d;

  logic                 commit;
  logic                 accept;
  logic [3:0]           nib_d [DIGITS];
  logic [DIGITS:0]      zero_above;
  logic [3:0]           cur_nib;
  logic [6:0]           dec_seg;
  logic                 lz_blank;

  // State, counters, value registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      seg_n_q      <= SEG_OFF;
      dig_n_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      seg_n_q      <= seg_n_d;
      dig_n_q      <= dig_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: sequence GAP/SHOW per digit and pick commit points.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          commit  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            commit = pend_vld_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow-register handshake; accept and commit can never coincide because
  // accept needs pend_vld low and commit needs it high.
  always_comb begin
    accept     = load_valid && !pend_vld_q;
    pend_d     = accept ? load_data : pend_q;
    disp_d     = commit ? pend_q : disp_q;
    pend_vld_d = pend_vld_q;
    if (accept) begin
      pend_vld_d = 1'b1;
    end else if (commit) begin
      pend_vld_d = 1'b0;
    end
  end

  // Outputs are computed from next-state values so they change on the same
  // edge as the state/index they reflect. zero_above[i] is set when nibble i
  // and every higher nibble are zero.
  assign zero_above[DIGITS] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib_d[gi]      = disp_d[4*gi +: 4];
    assign zero_above[gi] = zero_above[gi+1] & (nib_d[gi] == 4'h0);
  end

  assign cur_nib  = nib_d[idx_d];
  assign lz_blank = (BLANK_LZ != 0) && (idx_d != '0) && zero_above[idx_d];

  hex_seg_decode u_dec (
    .nib   (cur_nib),
    .seg_n (dec_seg)
  );

  // Output decode: light one digit in SHOW unless the display is forced dark.
  always_comb begin
    seg_n_d      = SEG_OFF;
    dig_n_d      = '1;
    frame_done_d = (state_d == ST_SHOW) && (cnt_d == DWELL_LAST) && (idx_d == IDX_LAST);
    if ((state_d == ST_SHOW) && !blank_en) begin
      dig_n_d = ~(DIG_ONE << idx_d);
      seg_n_d = lz_blank ? SEG_OFF : dec_seg;
    end
  end

  assign load_ready = !pend_vld_q;
  assign seg_n      = seg_n_q;
  assign dig_n      = dig_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode seven-segment display. It accepts a packed hex value over a valid/ready handshake and shares one hex-to-segment decoder across all digits. Digits are strobed one at a time with inter-digit ghost-blanking gaps and optional leading-zero suppression. The block sits between any register/counter producing display data and the board's segment and digit-enable pins; all segment and enable outputs are active-low.

## Interface
- DIGITS, 4: number of digits scanned (1–8).
- DWELL, 50000: clock cycles each digit is lit per visit (≥2).
- GAP, 2: all-off cycles before each digit (≥1).
- BLANK_LZ, 1: 1 = suppress leading zeros.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block can accept a load.
- load_data  in  4*DIGITS  packed nibbles; nibble 0 = least-significant digit.
- blank_en  in  1  force display dark; scanning continues.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dig_n  out  DIGITS  digit enables, active-low; bit i drives digit i.
- frame_done  out  1  one-cycle pulse at end of each full scan.

## Operation
- **Registers**
  - disp_reg: displayed value.
  - pend_reg + pend_vld: one-deep shadow register.
  - State machine, digit index, dwell counter.
- **Handshake**
  - load_ready = !pend_vld.
  - A transfer occurs when load_valid && load_ready on a clock edge; the value goes to pend_reg and pend_vld is set.
- **Commit**
  - pend_reg is copied to disp_reg only at a frame boundary, so a frame never shows a mix of old and new values.
  - pend_vld clears on the commit edge.
  - A load is not accepted on the commit edge itself, because load_ready is still 0 in that cycle.
- **States**
  - IDLE: after reset; display dark. Leaves on pend_vld: commit, index=0, go to GAP.
  - GAP: outputs dark for GAP cycles, then go to SHOW.
  - SHOW: digit at the current index is lit for DWELL cycles. On the last cycle:
    - if index = DIGITS-1: pulse frame_done, commit if pend_vld, wrap index to 0;
    - otherwise: index+1.
    - Then go to GAP.
- **Decode:** the nibble of disp_reg at the current index goes through the shared decoder. Glyphs use the standard active-low hex set: 0=1000000, 1=1111001, … A=0001000, F=0001110.
- **Leading-zero blanking:** when BLANK_LZ=1, digit i shows seg_n=7'h7F if it and every higher nibble are 0. Digit 0 is never blanked. dig_n is still asserted for a blanked digit.
- **blank_en:** seg_n=7'h7F and dig_n all ones while high. The state machine, counters and handshake are unaffected.
- **Reset mid-operation:** returns immediately to the IDLE values, and any pending load is discarded.

## Timing
- **Reset values:** seg_n=7'h7F, dig_n all ones, load_ready=1, frame_done=0, disp_reg=0, pend_vld=0, state IDLE.
- **Output registration:** seg_n, dig_n and frame_done are registered and change on the same edge as the state and index they reflect. blank_en takes effect one cycle after it is sampled.
- **Frame period:** DIGITS×(GAP+DWELL) cycles.
- **Dwell counter:** width $clog2(DWELL), counts 0..DWELL-1 and reloads, with no overflow.
- **First load:** from IDLE, accepted at edge T; commit and GAP entry at T+1; digit 0 lit at T+1+GAP.
- **Load latency while scanning:** load_ready falls the cycle after acceptance. New data appears at digit 0 of the next frame. load_ready rises the cycle after frame_done.

## Structure
- Shared package hex_disp_pkg holds:
  - state enum {IDLE, GAP, SHOW};
  - the 16-entry active-low glyph constant table;
  - the SEG_OFF = 7'h7F constant.
- One combinational sub-module, hex_seg_decode (4-bit in, 7-bit active-low out, table from the package), instantiated once.
- Index mux, leading-zero detect, FSM and counters stay in hex_scan_ctrl.

## Test plan
All scenarios use DIGITS=4, DWELL=4, GAP=2, BLANK_LZ=1.
- **Reset:** release rst with no load → seg_n=7F, dig_n=1111, load_ready=1, and no frame_done for 100 cycles.
- **First load 16'h12AF:** 2 dark cycles, then in order:
  - dig_n=1110, seg_n=0001110 (F) for 4 cycles;
  - gap, then dig_n=1101, seg_n=0001000 (A);
  - gap, then dig_n=1011, seg_n=0100100 (2);
  - gap, then dig_n=0111, seg_n=1111001 (1).
  - frame_done then pulses every 24 cycles.
- **Leading zeros, 16'h0030:** digits 3 and 2 show seg_n=7F with dig_n asserted; digit 1 = 0110000; digit 0 = 1000000.
- **Mid-frame load:** showing 16'h1111, load 16'h2222 during digit 1:
  - load_ready=0 the next cycle;
  - digits 2 and 3 still show 1;
  - after frame_done, digit 0 shows 0100100;
  - load_ready=1 the cycle after frame_done.
- **Back-to-back loads:** hold load_valid high with a changing value → only the first value and the value offered after load_ready returns high are accepted. The intermediate value is never displayed.
- **blank_en and async reset:** raise blank_en for 10 cycles mid-digit 2 → all dark, and frame_done timing is unchanged. Assert rst asynchronously mid-SHOW → outputs go to reset values without waiting for a clock edge, and the pending load is discarded.
